// File: rtl/matrix_out_writer_if.sv
// Bus bundle between the matrix output writer and its surroundings:
// job control/config, skewed column results, psum read port, output write port.
interface matrix_out_writer_if #(
  parameter int COL       = 4,
  parameter int ACC_WIDTH = 20,
  parameter int AW        = 9
);
  logic                          start;
  logic [AW-1:0]                 cfg_i_rows;
  logic [AW-1:0]                 cfg_psum_offset;
  logic [AW-1:0]                 cfg_o_offset_w;
  logic                          cfg_accum_en;
  logic [COL-1:0]                col_valid;
  logic [COL-1:0][ACC_WIDTH-1:0] col_data;
  logic                          psum_ren;
  logic [AW-1:0]                 psum_addr;
  logic [COL-1:0][ACC_WIDTH-1:0] psum_rdata;
  logic                          o_wen;
  logic [AW-1:0]                 o_addr;
  logic [COL-1:0][ACC_WIDTH-1:0] o_wdata;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output start, cfg_i_rows, cfg_psum_offset, cfg_o_offset_w, cfg_accum_en,
    output col_valid, col_data, psum_rdata,
    input  psum_ren, psum_addr, o_wen, o_addr, o_wdata, busy, done, err
  );

  modport slave (
    input  start, cfg_i_rows, cfg_psum_offset, cfg_o_offset_w, cfg_accum_en,
    input  col_valid, col_data, psum_rdata,
    output psum_ren, psum_addr, o_wen, o_addr, o_wdata, busy, done, err
  );
endinterface

// File: rtl/matrix_out_writer.sv
// De-skews column results leaving the systolic array into row vectors,
// optionally adds stored partial sums, and writes each row to output memory.
module matrix_out_writer #(
  parameter int WIDTH     = 8,
  parameter int COL       = 4,
  parameter int O_SIZE    = 512,
  parameter int MAX_ROW   = 16,
  parameter int ACC_WIDTH = 2*WIDTH+$clog2(MAX_ROW)
) (
  input logic          clk,
  input logic          rst,
  matrix_out_writer_if.slave bus
);
  localparam int AW = $clog2(O_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [COL-1:0][ACC_WIDTH-1:0] vec_t;

  // Base + offset modulo the memory depth (operands are already < O_SIZE).
  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= O_SIZE[AW:0]) s = s - O_SIZE[AW:0];
    return s[AW-1:0];
  endfunction

  // Per-column two's-complement add, wrapping at ACC_WIDTH bits.
  function automatic vec_t add_wrap(input vec_t a, input vec_t b);
    vec_t r;
    logic signed [ACC_WIDTH-1:0] sa, sb;
    for (int c = 0; c < COL; c++) begin
      sa   = signed'(a[c]);
      sb   = signed'(b[c]);
      r[c] = sa + sb;
    end
    return r;
  endfunction

  logic [COL-1:0] dly_vld;
  vec_t           dly_dat;

  for (genvar c = 0; c < COL; c++) begin : g_skew
    localparam int D = COL-1-c;
    if (D == 0) begin : g_pass
      assign dly_vld[c] = bus.col_valid[c];
      assign dly_dat[c] = bus.col_data[c];
    end else begin : g_sr
      logic [D-1:0]                vld_q, vld_d;
      logic [D-1:0][ACC_WIDTH-1:0] dat_q, dat_d;
      // Delay line: shifts every cycle, independent of job state
      always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = bus.col_valid[c];
        dat_d[0] = bus.col_data[c];
        for (int k = 1; k < D; k++) begin
          vld_d[k] = vld_q[k-1];
          dat_d[k] = dat_q[k-1];
        end
      end
      // Delay-line registers
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end
      assign dly_vld[c] = vld_q[D-1];
      assign dly_dat[c] = dat_q[D-1];
    end
  end

  state_t        state_q, state_d;
  logic [AW-1:0] row_cnt_q, row_cnt_d;
  logic [AW-1:0] i_rows_q, i_rows_d;
  logic [AW-1:0] psum_off_q, psum_off_d;
  logic [AW-1:0] o_off_q, o_off_d;
  logic          accum_q, accum_d;
  logic          err_q, err_d;
  logic          vld_p0_q, vld_p0_d;
  logic          last_p0_q, last_p0_d;
  vec_t          vec_p0_q, vec_p0_d;
  logic [AW-1:0] addr_p0_q, addr_p0_d;
  logic          o_wen_q, o_wen_d;
  logic [AW-1:0] o_addr_q, o_addr_d;
  vec_t          o_wdata_q, o_wdata_d;
  logic          done_q, done_d;

  logic aligned, skew_err, issue;
  assign aligned  = &dly_vld;
  assign skew_err = (|dly_vld) && !aligned;
  assign issue    = (state_q == RUN) && aligned && (row_cnt_q < i_rows_q);

  assign bus.psum_ren  = issue && accum_q;
  assign bus.psum_addr = bus.psum_ren ? wrap_addr(psum_off_q, row_cnt_q) : '0;
  assign bus.o_wen     = o_wen_q;
  assign bus.o_addr    = o_addr_q;
  assign bus.o_wdata   = o_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);

  // Job FSM, row issue and the two-stage write pipeline
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    i_rows_d   = i_rows_q;
    psum_off_d = psum_off_q;
    o_off_d    = o_off_q;
    accum_d    = accum_q;
    err_d      = err_q;
    vld_p0_d   = 1'b0;
    last_p0_d  = last_p0_q;
    vec_p0_d   = vec_p0_q;
    addr_p0_d  = addr_p0_q;
    o_addr_d   = o_addr_q;
    o_wdata_d  = o_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          i_rows_d   = bus.cfg_i_rows;
          psum_off_d = bus.cfg_psum_offset;
          o_off_d    = bus.cfg_o_offset_w;
          accum_d    = bus.cfg_accum_en;
          row_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = (bus.cfg_i_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (skew_err) err_d = 1'b1;
        // p0: capture the aligned row and its output address
        if (issue) begin
          vld_p0_d  = 1'b1;
          vec_p0_d  = dly_dat;
          addr_p0_d = wrap_addr(o_off_q, row_cnt_q);
          last_p0_d = (row_cnt_q == i_rows_q - AW'(1));
          row_cnt_d = row_cnt_q + AW'(1);
        end
        if (vld_p0_q && last_p0_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // p1: add the psum read that returns this cycle and register the write
    o_wen_d = vld_p0_q;
    if (vld_p0_q) begin
      o_addr_d  = addr_p0_q;
      o_wdata_d = add_wrap(vec_p0_q, accum_q ? bus.psum_rdata : '0);
    end
    done_d = (state_q == DONE);
  end

  // State and pipeline registers; reset abandons any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      i_rows_q   <= '0;
      psum_off_q <= '0;
      o_off_q    <= '0;
      accum_q    <= 1'b0;
      err_q      <= 1'b0;
      vld_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
      vec_p0_q   <= '0;
      addr_p0_q  <= '0;
      o_wen_q    <= 1'b0;
      o_addr_q   <= '0;
      o_wdata_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      i_rows_q   <= i_rows_d;
      psum_off_q <= psum_off_d;
      o_off_q    <= o_off_d;
      accum_q    <= accum_d;
      err_q      <= err_d;
      vld_p0_q   <= vld_p0_d;
      last_p0_q  <= last_p0_d;
      vec_p0_q   <= vec_p0_d;
      addr_p0_q  <= addr_p0_d;
      o_wen_q    <= o_wen_d;
      o_addr_q   <= o_addr_d;
      o_wdata_q  <= o_wdata_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: doc/matrix_out_writer.md
# matrix_out_writer

Result-drain end of the matrix-multiply datapath. It accepts the column-skewed partial-sum outputs leaving the bottom of the ROW×COL systolic array and de-skews them into one row vector per output row. When accumulation is enabled, it adds the previous partial sums read from the psum memory. It writes each finished row to output memory at `o_offset_w + row`, then reports completion to the controller.

## Interface
Parameters:
- `WIDTH`, 8: operand width.
- `COL`, 4: array columns.
- `O_SIZE`, 512: output/psum memory depth in words.
- `MAX_ROW`, 16: maximum weight rows; sets accumulator growth.
- `ACC_WIDTH`, 2*WIDTH+$clog2(MAX_ROW) = 20: per-column result width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle job start. Ignored unless state is IDLE.
- `cfg_i_rows` in $clog2(O_SIZE): number of rows to write.
- `cfg_psum_offset` in $clog2(O_SIZE): psum base address.
- `cfg_o_offset_w` in $clog2(O_SIZE): output base address.
- `cfg_accum_en` in 1: add psum memory contents.
- `col_valid` in COL: per-column result valid from the array.
- `col_data` in COL×ACC_WIDTH: per-column results, packed `[COL-1:0][ACC_WIDTH-1:0]`, two's complement.
- `psum_ren` out 1: psum read enable.
- `psum_addr` out $clog2(O_SIZE): psum read address.
- `psum_rdata` in COL×ACC_WIDTH: psum read data, valid 1 cycle after `psum_ren`.
- `o_wen` out 1: output memory write enable.
- `o_addr` out $clog2(O_SIZE): output write address.
- `o_wdata` out COL×ACC_WIDTH: output write data.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky skew-mismatch flag.

## Operation
- **Skew model:**
  - Row r leaves column c at cycle T_r + c.
  - Column c passes through a (COL-1-c)-stage shift register for both valid and data. Column COL-1 has zero delay.
  - All columns align in cycle L_r = T_r + COL-1.
- **Aligned valid:**
  - Aligned valid is the AND of all delayed valids.
  - If the delayed valids disagree in any cycle (some set, not all) and state is RUN, `err` sets. The row is not written in that case.
  - `err` clears only on `rst` or an accepted `start`.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE→RUN on `start`. On entry, latch all `cfg_*`, clear `row_cnt`, clear `err`.
  - If `cfg_i_rows`==0, go IDLE→DONE instead.
  - RUN: each aligned-valid cycle with `row_cnt` < `i_rows` issues one row and increments `row_cnt`.
  - RUN→DONE on the cycle after the write of row `i_rows`-1 is presented on `o_wen`.
  - DONE: `done`=1 for one cycle, then →IDLE.
- **Ignored traffic:** aligned valids in IDLE/DONE, or beyond `i_rows`, are dropped with no psum read and no write. The shift registers shift every cycle regardless of state.
- **Pipeline:**
  - Cycle L_r: if `accum_en`, `psum_ren`=1 (combinational) and `psum_addr` = (`psum_offset` + `row_cnt`) mod O_SIZE. The aligned vector and its address are registered.
  - Cycle L_r+1: `o_wdata` is registered as aligned + `psum_rdata`, or aligned + 0 when `accum_en`=0.
  - Cycle L_r+2: `o_wen`=1, `o_addr` = (`o_offset_w` + r) mod O_SIZE, `o_wdata` valid.
- **Arithmetic:** per-column ACC_WIDTH two's-complement add, wrapping mod 2^ACC_WIDTH, no saturation.
- **Address wrap:** addresses wrap mod O_SIZE.
- **Back-to-back rows** (aligned valid every cycle) are fully pipelined: one write per cycle.

## Timing
- **Reset values:** all outputs 0, state IDLE, shift registers and pipeline cleared. `rst` mid-job abandons it: no `done`, and in-flight writes are dropped.
- **Latency:** `o_wen` is high exactly 2 cycles after `col_valid[COL-1]` for that row.
- **Start-to-first-write:** a `start` accepted at cycle S allows rows whose L_r ≥ S+1.
- **`busy`:** high in RUN and DONE.
- **`start` in the DONE cycle:** ignored.
- **Output registers:** `o_wen`, `o_addr`, `o_wdata` and `done` are registered. `psum_ren` and `psum_addr` are combinational from registered state and the aligned valid.

## Test plan
- **De-skew, no accumulation.** `accum_en`=0, `i_rows`=2, `o_offset_w`=10. Inject row0 as columns {1,2,3,4} at cycles 5..8, and row1 as {5,6,7,8} at cycles 6..9. Required:
  - `o_wen` at cycles 10 and 11.
  - Addr 10 gets {1,2,3,4}; addr 11 gets {5,6,7,8}.
  - `done` at cycle 12.
- **Accumulation.** `accum_en`=1, `psum_offset`=100, memory[100]={10,10,10,10}, row {1,-1,0,2}. Required:
  - `psum_ren` with addr 100 at cycle L.
  - Write {11,9,10,12} at cycle L+2.
- **Wrap.** `o_offset_w`=511, `psum_offset`=511, `i_rows`=2. Required:
  - Writes go to 511 then 0, and psum reads to 511 then 0.
  - Column sum 0x7FFFF+1 writes 0x80000.
- **Skew fault.** Drop column 2 valid for row 0. Required: `err`=1, no write for that row, `err` held until the next `start`.
- **Boundary.** Both required:
  - `i_rows`=0: `done` 2 cycles after `start` with no writes.
  - Valids before `start`, and a 3rd row when `i_rows`=2, produce no writes.
- **Reset mid-job.** Assert `rst` during RUN with a row in flight. Required: next cycle all outputs 0, no `done`, and a subsequent job runs normally.
